approx_adder_error_monitor: RTL and testbench

- Sequential characterisation block for the approximate ripple-carry adder family (approximate low bits, exact high bits).
- Sweeps every operand pair into an external adder-under-test (AUT) and reads back each sum.
- Compares each sum against the exact sum and accumulates error metrics: error count, sum of absolute errors (for MAE), worst-case error and its operands.
- Sits beside the AUT in the FV/characterisation harness; handles combinational or pipelined AUTs.

---
 rtl/approx_adder_error_monitor.sv | 199 +++++++++++++++++++
 tb/tb_approx_adder_error_monitor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_error_monitor.sv
// Error-metric monitor for an approximate adder under test: sweeps every operand
// pair, aligns returning sums with a valid-tagged delay line and accumulates error stats.
module approx_adder_error_monitor #(
    parameter int W   = 8,
    parameter int LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic [W:0]       aut_sum,
    output logic             busy,
    output logic             done,
    output logic [2*W:0]     err_count,
    output logic [3*W:0]     sum_abs_err,
    output logic [W:0]       max_abs_err,
    output logic [W-1:0]     worst_a,
    output logic [W-1:0]     worst_b
);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    localparam int            DW         = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = (LAT > 0) ? DW'(LAT - 1) : '0;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_start_acc;

    logic [W-1:0]    r_op_a;
    logic [W-1:0]    r_op_b;
    logic            r_op_vld;
    logic            w_last;
    logic [DW-1:0]   r_drain_cnt;

    logic            w_tap_vld;
    logic [W-1:0]    w_tap_a;
    logic [W-1:0]    w_tap_b;

    logic [W:0]      w_exact;
    logic [W+1:0]    w_diff;
    logic [W:0]      w_ae;

    logic [2*W:0]    r_err_count;
    logic [3*W:0]    r_sum_abs_err;
    logic [W:0]      r_max_abs_err;
    logic [W-1:0]    r_worst_a;
    logic [W-1:0]    r_worst_b;

    // The final vector of the sweep; the first SWEEP cycle (r_op_vld low) is a settle cycle.
    assign w_last = r_op_vld && (&r_op_a) && (&r_op_b);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_SWEEP;
                end
            end
            S_SWEEP: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = (LAT == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (r_drain_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand sweep: op_b inner, op_a outer; operands hold once the sweep ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_vld    <= 1'b0;
            r_drain_cnt <= '0;
        end else begin
            if (w_start_acc) begin
                r_op_a   <= '0;
                r_op_b   <= '0;
                r_op_vld <= 1'b0;
            end else if (r_state == S_SWEEP) begin
                if (!r_op_vld) begin
                    r_op_vld <= 1'b1;
                end else if (w_last) begin
                    r_op_vld <= 1'b0;
                end else begin
                    {r_op_a, r_op_b} <= {r_op_a, r_op_b} + (2*W)'(1);
                end
            end

            if (r_state == S_SWEEP && w_last) begin
                r_drain_cnt <= DRAIN_INIT;
            end else if (r_state == S_DRAIN && r_drain_cnt != '0) begin
                r_drain_cnt <= r_drain_cnt - DW'(1);
            end
        end
    end

    generate
        if (LAT == 0) begin : g_no_delay
            assign w_tap_vld = r_op_vld;
            assign w_tap_a   = r_op_a;
            assign w_tap_b   = r_op_b;
        end else begin : g_delay
            logic [LAT-1:0] r_dl_vld;
            logic [W-1:0]   r_dl_a [LAT];
            logic [W-1:0]   r_dl_b [LAT];

            // NOTE: this small delay line is reset so stale tags never get scored after reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) begin
                        r_dl_vld[i] <= 1'b0;
                        r_dl_a[i]   <= '0;
                        r_dl_b[i]   <= '0;
                    end
                end else begin
                    r_dl_vld[0] <= r_op_vld;
                    r_dl_a[0]   <= r_op_a;
                    r_dl_b[0]   <= r_op_b;
                    for (int i = 1; i < LAT; i++) begin
                        r_dl_vld[i] <= r_dl_vld[i-1];
                        r_dl_a[i]   <= r_dl_a[i-1];
                        r_dl_b[i]   <= r_dl_b[i-1];
                    end
                end
            end

            assign w_tap_vld = r_dl_vld[LAT-1];
            assign w_tap_a   = r_dl_a[LAT-1];
            assign w_tap_b   = r_dl_b[LAT-1];
        end
    endgenerate

    // Absolute error from a W+2-bit signed difference; magnitude always fits W+1 bits.
    assign w_exact = {1'b0, w_tap_a} + {1'b0, w_tap_b};
    assign w_diff  = {1'b0, aut_sum} - {1'b0, w_exact};
    assign w_ae    = w_diff[W+1] ? (W+1)'(-w_diff) : w_diff[W:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count   <= '0;
            r_sum_abs_err <= '0;
            r_max_abs_err <= '0;
            r_worst_a     <= '0;
            r_worst_b     <= '0;
        end else if (w_start_acc) begin
            r_err_count   <= '0;
            r_sum_abs_err <= '0;
            r_max_abs_err <= '0;
            r_worst_a     <= '0;
            r_worst_b     <= '0;
        end else if (w_tap_vld) begin
            r_err_count   <= r_err_count + {{(2*W){1'b0}}, (w_ae != '0)};
            r_sum_abs_err <= r_sum_abs_err + {{(2*W){1'b0}}, w_ae};
            if (w_ae > r_max_abs_err) begin
                r_max_abs_err <= w_ae;
                r_worst_a     <= w_tap_a;
                r_worst_b     <= w_tap_b;
            end
        end
    end

    assign op_a        = r_op_a;
    assign op_b        = r_op_b;
    assign err_count   = r_err_count;
    assign sum_abs_err = r_sum_abs_err;
    assign max_abs_err = r_max_abs_err;
    assign worst_a     = r_worst_a;
    assign worst_b     = r_worst_b;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Self-checking bench: two monitors (LAT=0 and LAT=2) at W=4 driven by stub adders,
// table-driven sweeps scored through an expected-result queue, plus restart/reset sequences.
module tb_approx_adder_error_monitor;

    localparam int W = 4;

    typedef struct {
        int mode;     // stub behaviour for the LAT=0 monitor
        int sel;      // 0: LAT=0 monitor, 1: LAT=2 monitor
        int exp_err;
        int exp_sum;
        int exp_max;
        int exp_wa;
        int exp_wb;
        int exp_lat;  // edges from start-sampling edge to done
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;

    logic [W-1:0]   d0_op_a, d0_op_b, d0_worst_a, d0_worst_b;
    logic [W:0]     d0_aut, d0_max;
    logic           d0_busy, d0_done;
    logic [2*W:0]   d0_err;
    logic [3*W:0]   d0_sum;

    logic [W-1:0]   d2_op_a, d2_op_b, d2_worst_a, d2_worst_b;
    logic [W:0]     d2_aut, d2_max;
    logic           d2_busy, d2_done;
    logic [2*W:0]   d2_err;
    logic [3*W:0]   d2_sum;

    logic [W:0]     p0_s1, p0_s2, p2_s1, p2_s2, exact0, exact2;

    int             mode = 0;
    int             sel = 0;
    int             n_tests = 0;
    int             n_fail = 0;
    vec_t           cases [6];
    vec_t           sb_q [$];

    logic           s_done, s_busy;
    logic [2*W:0]   s_err;
    logic [3*W:0]   s_sum;
    logic [W:0]     s_max;
    logic [W-1:0]   s_wa, s_wb;

    always #5 clk = ~clk;

    approx_adder_error_monitor #(.W(W), .LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .op_a(d0_op_a), .op_b(d0_op_b), .aut_sum(d0_aut),
        .busy(d0_busy), .done(d0_done),
        .err_count(d0_err), .sum_abs_err(d0_sum), .max_abs_err(d0_max),
        .worst_a(d0_worst_a), .worst_b(d0_worst_b)
    );

    approx_adder_error_monitor #(.W(W), .LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .op_a(d2_op_a), .op_b(d2_op_b), .aut_sum(d2_aut),
        .busy(d2_busy), .done(d2_done),
        .err_count(d2_err), .sum_abs_err(d2_sum), .max_abs_err(d2_max),
        .worst_a(d2_worst_a), .worst_b(d2_worst_b)
    );

    assign exact0 = {1'b0, d0_op_a} + {1'b0, d0_op_b};
    assign exact2 = {1'b0, d2_op_a} + {1'b0, d2_op_b};

    // Two-stage registered exact adders.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_s1 <= '0;
            p0_s2 <= '0;
            p2_s1 <= '0;
            p2_s2 <= '0;
        end else begin
            p0_s1 <= exact0;
            p0_s2 <= p0_s1;
            p2_s1 <= exact2;
            p2_s2 <= p2_s1;
        end
    end

    assign d2_aut = p2_s2;

    always_comb begin
        d0_aut = exact0;
        case (mode)
            1: d0_aut = '0;
            2: d0_aut = (d0_op_a == 4'd3 && d0_op_b == 4'd5) ? exact0 + 5'd1 : exact0;
            3: d0_aut = ((d0_op_a == 4'd7 && d0_op_b == 4'd1) ||
                         (d0_op_a == 4'd9 && d0_op_b == 4'd9)) ? exact0 - 5'd2 : exact0;
            4: d0_aut = p0_s2;
            default: d0_aut = exact0;
        endcase
    end

    always_comb begin
        if (sel == 1) begin
            s_done = d2_done; s_busy = d2_busy; s_err = d2_err; s_sum = d2_sum;
            s_max = d2_max; s_wa = d2_worst_a; s_wb = d2_worst_b;
        end else begin
            s_done = d0_done; s_busy = d0_busy; s_err = d0_err; s_sum = d0_sum;
            s_max = d0_max; s_wa = d0_worst_a; s_wb = d0_worst_b;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op_a"},  d0_op_a,    0);
        check({tag, "_op_b"},  d0_op_b,    0);
        check({tag, "_busy"},  d0_busy,    0);
        check({tag, "_done"},  d0_done,    0);
        check({tag, "_err"},   d0_err,     0);
        check({tag, "_sum"},   d0_sum,     0);
        check({tag, "_max"},   d0_max,     0);
        check({tag, "_wa"},    d0_worst_a, 0);
        check({tag, "_wb"},    d0_worst_b, 0);
        check({tag, "_busy2"}, d2_busy,    0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
    endtask

    // Returns one time unit after the edge that samples start.
    task automatic start_pulse();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!s_done && n < 2000);
    endtask

    task automatic run_case(input string tag, input vec_t v, input bit rst_first);
        int   n;
        vec_t e;
        mode = v.mode;
        sel  = v.sel;
        if (rst_first) do_reset();
        sb_q.push_back(v);
        start_pulse();
        wait_done(n);
        e = sb_q.pop_front();
        check({tag, "_latency"}, n, e.exp_lat);
        check({tag, "_busy_at_done"}, s_busy, 0);
        check({tag, "_err"}, s_err, e.exp_err);
        check({tag, "_sum"}, s_sum, e.exp_sum);
        check({tag, "_max"}, s_max, e.exp_max);
        check({tag, "_worst_a"}, s_wa, e.exp_wa);
        check({tag, "_worst_b"}, s_wb, e.exp_wb);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, s_done, 0);
    endtask

    initial begin
        int n;
        int n_done;

        // mode, sel, err, sum, max, worst_a, worst_b, latency
        cases[0] = '{0, 0,   0,    0,  0,  0,  0, 257};  // exact adder
        cases[1] = '{1, 0, 255, 3840, 30, 15, 15, 257};  // constant-zero sum
        cases[2] = '{2, 0,   1,    1,  1,  3,  5, 257};  // +1 at (3,5)
        cases[3] = '{3, 0,   2,    4,  2,  7,  1, 257};  // -2 at (7,1),(9,9): first kept
        cases[4] = '{4, 0, 255,  839, 13,  1,  0, 257};  // 2-stage adder, misaligned
        cases[5] = '{0, 1,   0,    0,  0,  0,  0, 259};  // 2-stage adder, LAT=2

        do_reset();
        #1;
        check_reset_outputs("reset");

        for (int i = 0; i < 6; i++) begin
            run_case($sformatf("case%0d", i), cases[i], 1'b1);
        end

        // start pulses mid-sweep and while done are ignored; start right after done restarts.
        mode = 1;
        sel  = 0;
        do_reset();
        start_pulse();
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 10) start = 1'b1;
            if (n == 11) start = 1'b0;
        end while (!d0_done && n < 2000);
        check("restart_ignored_latency", n, 257);
        check("restart_ignored_err", d0_err, 255);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("start_in_done_busy", d0_busy, 0);
        check("start_in_done_no_second_done", d0_done, 0);
        @(posedge clk);
        #1 start = 1'b0;
        check("fresh_sweep_busy", d0_busy, 1);
        check("fresh_sweep_err_cleared", d0_err, 0);
        check("fresh_sweep_sum_cleared", d0_sum, 0);
        check("fresh_sweep_max_cleared", d0_max, 0);
        check("fresh_sweep_wa_cleared", d0_worst_a, 0);
        check("fresh_sweep_op_a", d0_op_a, 0);
        check("fresh_sweep_op_b", d0_op_b, 0);
        wait_done(n);
        check("fresh_sweep_latency", n, 257);
        check("fresh_sweep_sum", d0_sum, 3840);
        check("fresh_sweep_max", d0_max, 30);

        // Asynchronous reset mid-sweep aborts without a done pulse.
        do_reset();
        start_pulse();
        repeat (100) @(posedge clk);
        #1;
        check("pre_abort_busy", d0_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        #1 rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (d0_done || d2_done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_case("after_abort", cases[1], 1'b0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
